// File: rtl/mesh_local_port.sv
// Router-side endpoint of the PE<->mesh local port.
// Buffers PE flits toward the router and router flits toward the PE.
module mesh_local_port #(
  parameter int FLIT_LENGTH = 72,
  parameter int IN_DEPTH    = 4,
  parameter int OUT_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             lx,
  input  logic [2:0]             ly,
  input  logic                   reqin,
  output logic                   ackin,
  input  logic [FLIT_LENGTH-1:0] datain,
  output logic                   reqout,
  input  logic                   ackout,
  output logic [FLIT_LENGTH-1:0] dataout,
  output logic                   inj_valid,
  input  logic                   inj_ready,
  output logic [FLIT_LENGTH-1:0] inj_flit,
  input  logic                   ej_valid,
  output logic                   ej_ready,
  input  logic [FLIT_LENGTH-1:0] ej_flit,
  output logic [15:0]            cnt_in,
  output logic [15:0]            cnt_out
);

  localparam int W  = FLIT_LENGTH;
  localparam int IA = $clog2(IN_DEPTH);
  localparam int OA = $clog2(OUT_DEPTH);

  logic [W-1:0] in_mem  [IN_DEPTH];
  logic [W-1:0] out_mem [OUT_DEPTH];
  logic [IA:0]  in_wp, in_rp;
  logic [OA:0]  out_wp, out_rp;

  logic         in_empty, in_full;
  logic         out_empty, out_full;
  logic [W-1:0] in_head, out_head;
  logic         is_local;
  logic         in_push, in_pop;
  logic         ej_push, lb_push;
  logic         out_push, out_pop;
  logic [W-1:0] out_din;

  assign in_empty = (in_wp == in_rp);
  assign in_full  = (in_wp[IA] != in_rp[IA]) &&
                    (in_wp[IA-1:0] == in_rp[IA-1:0]);
  assign out_empty = (out_wp == out_rp);
  assign out_full  = (out_wp[OA] != out_rp[OA]) &&
                     (out_wp[OA-1:0] == out_rp[OA-1:0]);

  assign in_head  = in_mem[in_rp[IA-1:0]];
  assign out_head = out_mem[out_rp[OA-1:0]];

  assign is_local = (in_head[W-1:W-3] == lx) &&
                    (in_head[W-4:W-6] == ly);

  assign ackin   = reqin & ~in_full & ~rst;
  assign in_push = reqin & ackin;

  assign inj_valid = ~in_empty & ~is_local;
  assign inj_flit  = in_head;

  // Router ejection always wins the single egress write port
  assign ej_ready = ~out_full;
  assign ej_push  = ej_valid & ej_ready;
  assign lb_push  = ~in_empty & is_local & ~ej_valid & ~out_full;

  assign in_pop   = (inj_valid & inj_ready) | lb_push;
  assign out_push = ej_push | lb_push;
  assign out_din  = ej_push ? ej_flit : in_head;

  assign reqout  = ~out_empty;
  assign dataout = out_empty ? '0 : out_head;
  assign out_pop = reqout & ackout;

  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wp[IA-1:0]] <= datain;
    if (out_push) out_mem[out_wp[OA-1:0]] <= out_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_wp   <= '0;
      in_rp   <= '0;
      out_wp  <= '0;
      out_rp  <= '0;
      cnt_in  <= '0;
      cnt_out <= '0;
    end else begin
      if (in_push) begin
        in_wp  <= in_wp + {{IA{1'b0}}, 1'b1};
        cnt_in <= cnt_in + 16'd1;
      end
      if (in_pop) in_rp <= in_rp + {{IA{1'b0}}, 1'b1};
      if (out_push) out_wp <= out_wp + {{OA{1'b0}}, 1'b1};
      if (out_pop) begin
        out_rp  <= out_rp + {{OA{1'b0}}, 1'b1};
        cnt_out <= cnt_out + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mesh_local_port.sv
// Directed and randomized checks of mesh_local_port
// against a queue-level reference model.
module tb_mesh_local_port;

  localparam int W  = 72;
  localparam int ID = 4;
  localparam int OD = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   lx, ly;
  logic         reqin, ackin;
  logic [W-1:0] datain;
  logic         reqout, ackout;
  logic [W-1:0] dataout;
  logic         inj_valid, inj_ready;
  logic [W-1:0] inj_flit;
  logic         ej_valid, ej_ready;
  logic [W-1:0] ej_flit;
  logic [15:0]  cnt_in, cnt_out;

  mesh_local_port #(.FLIT_LENGTH(W), .IN_DEPTH(ID), .OUT_DEPTH(OD)) dut (
    .clk(clk), .rst(rst), .lx(lx), .ly(ly),
    .reqin(reqin), .ackin(ackin), .datain(datain),
    .reqout(reqout), .ackout(ackout), .dataout(dataout),
    .inj_valid(inj_valid), .inj_ready(inj_ready), .inj_flit(inj_flit),
    .ej_valid(ej_valid), .ej_ready(ej_ready), .ej_flit(ej_flit),
    .cnt_in(cnt_in), .cnt_out(cnt_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] inq [$];
  logic [W-1:0] outq [$];
  logic [15:0]  m_cin, m_cout;

  function automatic logic [W-1:0] mk(int x, int y, int num);
    logic [W-1:0] f;
    f = '0;
    f[W-1:W-3] = x[2:0];
    f[W-4:W-6] = y[2:0];
    f[W-15:16] = 42'($urandom);
    f[15:0]    = num[15:0];
    return f;
  endfunction

  task automatic check(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: compare DUT with the model, then advance both
  task automatic tick();
    logic [W-1:0] hd, e_do;
    bit lcl, e_ack, e_inj, e_lb, e_ej, e_op;
    #1;
    if (rst) begin
      inq.delete();
      outq.delete();
      m_cin  = '0;
      m_cout = '0;
    end
    hd    = (inq.size() > 0) ? inq[0] : '0;
    lcl   = (inq.size() > 0) && hd[W-1:W-3] == lx && hd[W-4:W-6] == ly;
    e_ack = !rst && reqin && inq.size() < ID;
    e_inj = (inq.size() > 0) && !lcl;
    e_lb  = lcl && !ej_valid && outq.size() < OD;
    e_ej  = ej_valid && outq.size() < OD;
    e_op  = (outq.size() > 0) && ackout;
    e_do  = (outq.size() > 0) ? outq[0] : '0;
    check("ackin", W'(ackin), W'(e_ack));
    check("inj_valid", W'(inj_valid), W'(e_inj));
    check("ej_ready", W'(ej_ready), W'(outq.size() < OD));
    check("reqout", W'(reqout), W'(outq.size() > 0));
    check("dataout", dataout, e_do);
    check("cnt_in", W'(cnt_in), W'(m_cin));
    check("cnt_out", W'(cnt_out), W'(m_cout));
    if (e_inj) check("inj_flit", inj_flit, hd);
    if (!rst) begin
      if ((e_inj && inj_ready) || e_lb) void'(inq.pop_front());
      if (e_op) begin
        void'(outq.pop_front());
        m_cout++;
      end
      if (e_lb) outq.push_back(hd);
      if (e_ej) outq.push_back(ej_flit);
      if (e_ack) begin
        inq.push_back(datain);
        m_cin++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(string tag);
    reqin = 0; ej_valid = 0; inj_ready = 1; ackout = 1;
    for (int k = 0; k < 64 && (inq.size() + outq.size()) > 0; k++) tick();
    check(tag, W'({reqout, inj_valid}), '0);
  endtask

  logic [W-1:0] f;
  logic [15:0]  b0, d;
  int           pushed;

  initial begin
    rst = 1; lx = 0; ly = 0; reqin = 0; datain = '0; ackout = 0;
    inj_ready = 0; ej_valid = 0; ej_flit = '0;
    m_cin = '0; m_cout = '0;
    repeat (4) tick();
    rst = 0;

    // single injection toward (1,0)
    inj_ready = 1; reqin = 1; f = mk(1, 0, 5); datain = f;
    tick();
    reqin = 0;
    check("t2_inj_valid", W'(inj_valid), W'(1'b1));
    check("t2_inj_flit", inj_flit, f);
    check("t2_cnt_in", W'(cnt_in), W'(16'd1));
    tick();

    // backpressure: fifth flit refused
    inj_ready = 0;
    for (int i = 1; i <= 5; i++) begin
      reqin = 1; datain = mk(2, 3, i);
      #1 check("t3_ackin", W'(ackin), W'(i < 5));
      tick();
    end
    reqin = 0; inj_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      check("t3_order", W'(inj_flit[15:0]), W'(i));
      tick();
    end
    tick();

    // loopback at node (1,1)
    lx = 1; ly = 1; ackout = 1;
    b0 = cnt_out;
    reqin = 1; datain = mk(1, 1, 9);
    tick();
    reqin = 0;
    check("t4_no_inj", W'(inj_valid), '0);
    tick();
    check("t4_reqout", W'(reqout), W'(1'b1));
    check("t4_num", W'(dataout[15:0]), W'(16'd9));
    tick();
    d = cnt_out - b0;
    check("t4_cnt_out", W'(d), W'(16'd1));

    // collision: ejection starves the waiting local flit
    reqin = 1; datain = mk(1, 1, 77);
    ej_valid = 1; ej_flit = mk(1, 1, 1000);
    tick();
    reqin = 0;
    for (int i = 0; i < 6; i++) begin
      ej_flit = mk(1, 1, 1001 + i);
      tick();
    end
    ej_valid = 0;
    drain("t5_stall_drain");

    // randomized traffic over a 2x2 mesh, 64 PE flits
    b0 = cnt_in;
    for (int k = 0; k < 4000; k++) begin
      d = cnt_in - b0;
      if (d >= 16'd64) break;
      reqin     = 1'($urandom_range(0, 1));
      datain    = mk($urandom_range(0, 1), $urandom_range(0, 1), 100 + int'(d));
      ej_valid  = ($urandom_range(0, 3) != 0);
      ej_flit   = mk(1, 1, $urandom_range(0, 65535));
      ackout    = 1'($urandom_range(0, 1));
      inj_ready = 1'($urandom_range(0, 1));
      tick();
    end
    d = cnt_in - b0;
    check("t5_accepted", W'(d), W'(16'd64));
    drain("t5_drain");

    // reset with flits buffered on both sides
    ackout = 0; ej_valid = 1; ej_flit = mk(1, 1, 300);
    reqin = 1; inj_ready = 0; datain = mk(0, 0, 301);
    tick(); tick();
    reqin = 0; ej_valid = 0;
    rst = 1;
    tick();
    check("rst_reqout", W'(reqout), '0);
    check("rst_dataout", dataout, '0);
    check("rst_inj_valid", W'(inj_valid), '0);
    tick();
    rst = 0;

    // egress full, then drain while refilling across the wrap
    ackout = 0; ej_valid = 1;
    for (int i = 0; i < 4; i++) begin
      ej_flit = mk(1, 1, 200 + i);
      tick();
    end
    ej_flit = mk(1, 1, 204);
    check("t6_ej_ready", W'(ej_ready), '0);
    ackout = 1;
    pushed = 4;
    for (int k = 0; k < 100 && pushed < 12; k++) begin
      ej_flit = mk(1, 1, 200 + pushed);
      if (outq.size() < OD) pushed++;
      tick();
    end
    drain("t6_drain");
    check("t6_cnt_out", W'(cnt_out), W'(16'd12));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
